// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : univ_shift_reg
//  Purpose  : Parametrised universal shift register. Holds a WIDTH-bit word
//             that can be held, parallel-loaded, shifted or rotated in either
//             direction, or synchronously cleared. Counts shift/rotate
//             operations since the last load/clear/reset (saturating) and
//             flags when that count has reached WIDTH.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH       register width in bits (>= 1)
//    CNT_W       width of shift_count (2**CNT_W - 1 >= WIDTH)
//    RESET_VAL   value of q after reset or clear
//  Ports
//    clock        in   1      rising-edge clock
//    resetn       in   1      asynchronous active-low reset
//    enable       in   1      0 = all state holds
//    mode         in   3      000 hold, 001 shr, 010 shl, 011 load,
//                             100 rotr, 101 rotl, 110 clear, 111 hold
//    d            in   WIDTH  parallel load data
//    sin_right    in   1      bit entering the MSB on shift right
//    sin_left     in   1      bit entering the LSB on shift left
//    q            out  WIDTH  register contents
//    sout         out  1      bit that left on the most recent shift/rotate
//    shift_count  out  CNT_W  saturating shift/rotate counter
//    done         out  1      shift_count >= WIDTH
//  Build option
//    USR_ROTATE_EN  defined   : modes 100/101 rotate
//                   undefined : modes 100/101 behave as hold
// ============================================================================
module univ_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter int                 CNT_W     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               enable,
    input  logic [2:0]         mode,
    input  logic [WIDTH-1:0]   d,
    input  logic               sin_right,
    input  logic               sin_left,
    output logic [WIDTH-1:0]   q,
    output logic               sout,
    output logic [CNT_W-1:0]   shift_count,
    output logic               done
);

    // ------------------------------------------------------------------
    // Operation encodings
    // ------------------------------------------------------------------
    localparam logic [2:0] c_MODE_HOLD  = 3'b000;
    localparam logic [2:0] c_MODE_SHR   = 3'b001;
    localparam logic [2:0] c_MODE_SHL   = 3'b010;
    localparam logic [2:0] c_MODE_LOAD  = 3'b011;
    localparam logic [2:0] c_MODE_ROTR  = 3'b100;
    localparam logic [2:0] c_MODE_ROTL  = 3'b101;
    localparam logic [2:0] c_MODE_CLEAR = 3'b110;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    // WIDTH expressed one bit wider than the counter so the done compare
    // is unsigned and width-matched.
    localparam logic [CNT_W:0]   c_WIDTH_CNT = (CNT_W+1)'(WIDTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    // ------------------------------------------------------------------
    // Candidate next words for each movement. A 1-bit register has no
    // q[WIDTH-2:0] slice, so it gets its own trivial forms.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_rotr;
    logic [WIDTH-1:0] w_rotl;
    logic             w_lsb;
    logic             w_msb;

    assign w_lsb = r_q[0];
    assign w_msb = r_q[WIDTH-1];

    generate
        if (WIDTH == 1) begin : g_w1
            assign w_shr  = sin_right;
            assign w_shl  = sin_left;
            assign w_rotr = r_q;
            assign w_rotl = r_q;
        end else begin : g_wn
            assign w_shr  = {sin_right, r_q[WIDTH-1:1]};
            assign w_shl  = {r_q[WIDTH-2:0], sin_left};
            assign w_rotr = {r_q[0], r_q[WIDTH-1:1]};
            assign w_rotl = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_sout_nxt;
    logic             w_is_shift;   // movement that bumps the counter
    logic             w_is_zero;    // load/clear: counter and flags restart
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_done_nxt;

    always_comb begin
        w_q_nxt    = r_q;
        w_sout_nxt = r_sout;
        w_is_shift = 1'b0;
        w_is_zero  = 1'b0;

        case (mode)
            c_MODE_SHR: begin
                w_q_nxt    = w_shr;
                w_sout_nxt = w_lsb;
                w_is_shift = 1'b1;
            end
            c_MODE_SHL: begin
                w_q_nxt    = w_shl;
                w_sout_nxt = w_msb;
                w_is_shift = 1'b1;
            end
            c_MODE_LOAD: begin
                w_q_nxt    = d;
                w_sout_nxt = 1'b0;
                w_is_zero  = 1'b1;
            end
`ifdef USR_ROTATE_EN
            c_MODE_ROTR: begin
                w_q_nxt    = w_rotr;
                w_sout_nxt = w_lsb;
                w_is_shift = 1'b1;
            end
            c_MODE_ROTL: begin
                w_q_nxt    = w_rotl;
                w_sout_nxt = w_msb;
                w_is_shift = 1'b1;
            end
`else
            // Rotation compiled out: these codes leave every register alone.
            c_MODE_ROTR,
            c_MODE_ROTL: begin
                w_q_nxt    = r_q;
                w_sout_nxt = r_sout;
            end
`endif
            c_MODE_CLEAR: begin
                w_q_nxt    = RESET_VAL;
                w_sout_nxt = 1'b0;
                w_is_zero  = 1'b1;
            end
            c_MODE_HOLD: begin
                w_q_nxt    = r_q;
                w_sout_nxt = r_sout;
            end
            default: begin
                // 111 is reserved and acts as hold.
                w_q_nxt    = r_q;
                w_sout_nxt = r_sout;
            end
        endcase
    end

    // Counter saturates at all-ones and never wraps.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_is_zero) begin
            w_cnt_nxt = '0;
        end else if (w_is_shift && (r_cnt != c_CNT_MAX)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // done tracks the count that will be stored, so it is valid in the same
    // cycle shift_count shows the new value.
    assign w_done_nxt = ({1'b0, w_cnt_nxt} >= c_WIDTH_CNT);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_q    <= RESET_VAL;
            r_sout <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (enable) begin
            r_q    <= w_q_nxt;
            r_sout <= w_sout_nxt;
            r_cnt  <= w_cnt_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign q           = r_q;
    assign sout        = r_sout;
    assign shift_count = r_cnt;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_univ_shift_reg
//  Purpose  : Directed self-checking bench for univ_shift_reg (WIDTH=8,
//             CNT_W=4, RESET_VAL=0). Expected values are hand-computed.
//             Rotation expectations follow USR_ROTATE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_univ_shift_reg;

    localparam int c_WIDTH = 8;
    localparam int c_CNT_W = 4;

    logic                 r_clock;
    logic                 r_resetn;
    logic                 r_enable;
    logic [2:0]           r_mode;
    logic [c_WIDTH-1:0]   r_d;
    logic                 r_sin_right;
    logic                 r_sin_left;
    logic [c_WIDTH-1:0]   w_q;
    logic                 w_sout;
    logic [c_CNT_W-1:0]   w_shift_count;
    logic                 w_done;

    int r_total;
    int r_bad;

    univ_shift_reg #(
        .WIDTH     (c_WIDTH),
        .CNT_W     (c_CNT_W),
        .RESET_VAL (8'h00)
    ) u_dut (
        .clock       (r_clock),
        .resetn      (r_resetn),
        .enable      (r_enable),
        .mode        (r_mode),
        .d           (r_d),
        .sin_right   (r_sin_right),
        .sin_left    (r_sin_left),
        .q           (w_q),
        .sout        (w_sout),
        .shift_count (w_shift_count),
        .done        (w_done)
    );

    initial r_clock = 1'b0;
    always #5 r_clock = ~r_clock;

    task automatic chk_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        r_total = r_total + 1;
        if (obs !== exp) begin
            r_bad = r_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one operation, let it be sampled, then settle 1ns past the edge.
    task automatic do_op(input logic [2:0] m, input logic [7:0] dv,
                         input logic sr, input logic sl, input logic en);
        r_mode      = m;
        r_d         = dv;
        r_sin_right = sr;
        r_sin_left  = sl;
        r_enable    = en;
        @(posedge r_clock);
        #1;
    endtask

    // Expected serialiser output for 8'hB4 shifted right, LSB first.
    logic [7:0] r_ser_exp;

    initial begin
        r_total     = 0;
        r_bad       = 0;
        r_resetn    = 1'b0;
        r_enable    = 1'b0;
        r_mode      = 3'b000;
        r_d         = 8'h00;
        r_sin_right = 1'b0;
        r_sin_left  = 1'b0;
        r_ser_exp   = 8'b1011_0100;

        // ---------------- reset state ----------------
        repeat (2) @(posedge r_clock);
        #1;
        chk_val("rst_q",    32'(w_q),           32'h00);
        chk_val("rst_sout", 32'(w_sout),        32'h0);
        chk_val("rst_cnt",  32'(w_shift_count), 32'h0);
        chk_val("rst_done", 32'(w_done),        32'h0);
        r_resetn = 1'b1;

        // ---------------- async reset mid-operation ----------------
        do_op(3'b011, 8'hA5, 1'b0, 1'b0, 1'b1);
        chk_val("ld_a5_q", 32'(w_q), 32'hA5);
        do_op(3'b001, 8'h00, 1'b0, 1'b0, 1'b1);
        chk_val("shr_a5_q",    32'(w_q),           32'h52);
        chk_val("shr_a5_sout", 32'(w_sout),        32'h1);
        chk_val("shr_a5_cnt",  32'(w_shift_count), 32'h1);
        #2;                      // between edges
        r_resetn = 1'b0;
        #1;
        chk_val("arst_q",    32'(w_q),           32'h00);
        chk_val("arst_sout", 32'(w_sout),        32'h0);
        chk_val("arst_cnt",  32'(w_shift_count), 32'h0);
        chk_val("arst_done", 32'(w_done),        32'h0);
        @(negedge r_clock);
        r_resetn = 1'b1;
        do_op(3'b011, 8'h5A, 1'b0, 1'b0, 1'b1);
        chk_val("post_rst_ld", 32'(w_q), 32'h5A);

        // ---------------- serialise 8'hB4 ----------------
        do_op(3'b011, 8'hB4, 1'b0, 1'b0, 1'b1);
        chk_val("ser_ld_q", 32'(w_q), 32'hB4);
        for (int i = 0; i < 8; i++) begin
            do_op(3'b001, 8'h00, 1'b0, 1'b0, 1'b1);
            chk_val($sformatf("ser_sout%0d", i), 32'(w_sout), 32'(r_ser_exp[i]));
            chk_val($sformatf("ser_done%0d", i), 32'(w_done), (i == 7) ? 32'h1 : 32'h0);
        end
        chk_val("ser_q",   32'(w_q),           32'h00);
        chk_val("ser_cnt", 32'(w_shift_count), 32'h8);

        // ---------------- rotate left 8'h81 ----------------
        do_op(3'b011, 8'h81, 1'b0, 1'b0, 1'b1);
        chk_val("rot_ld_sout", 32'(w_sout), 32'h0);
        chk_val("rot_ld_done", 32'(w_done), 32'h0);
        do_op(3'b101, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef USR_ROTATE_EN
        chk_val("rotl1_q",    32'(w_q),    32'h03);
        chk_val("rotl1_sout", 32'(w_sout), 32'h1);
`else
        chk_val("rotl1_q",    32'(w_q),    32'h81);
        chk_val("rotl1_sout", 32'(w_sout), 32'h0);
`endif
        repeat (7) do_op(3'b101, 8'h00, 1'b0, 1'b0, 1'b1);
        chk_val("rotl_q", 32'(w_q), 32'h81);
`ifdef USR_ROTATE_EN
        chk_val("rotl_cnt",  32'(w_shift_count), 32'h8);
        chk_val("rotl_done", 32'(w_done),        32'h1);
`else
        chk_val("rotl_cnt",  32'(w_shift_count), 32'h0);
        chk_val("rotl_done", 32'(w_done),        32'h0);
`endif

        // ---------------- rotate right 8'h01 ----------------
        do_op(3'b011, 8'h01, 1'b0, 1'b0, 1'b1);
        do_op(3'b100, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef USR_ROTATE_EN
        chk_val("rotr_q",    32'(w_q),           32'h80);
        chk_val("rotr_sout", 32'(w_sout),        32'h1);
        chk_val("rotr_cnt",  32'(w_shift_count), 32'h1);
`else
        chk_val("rotr_q",    32'(w_q),           32'h01);
        chk_val("rotr_sout", 32'(w_sout),        32'h0);
        chk_val("rotr_cnt",  32'(w_shift_count), 32'h0);
`endif

        // ---------------- saturation with shift left ----------------
        do_op(3'b011, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            do_op(3'b010, 8'h00, 1'b0, 1'b1, 1'b1);
            if (i == 7) begin
                chk_val("sat_done_at8", 32'(w_done), 32'h1);
            end
        end
        chk_val("sat_q",    32'(w_q),           32'hFF);
        chk_val("sat_cnt",  32'(w_shift_count), 32'hF);
        chk_val("sat_done", 32'(w_done),        32'h1);
        chk_val("sat_sout", 32'(w_sout),        32'h1);

        // ---------------- enable low holds everything ----------------
        repeat (3) do_op(3'b001, 8'h00, 1'b0, 1'b0, 1'b0);
        chk_val("en0_q",    32'(w_q),           32'hFF);
        chk_val("en0_sout", 32'(w_sout),        32'h1);
        chk_val("en0_cnt",  32'(w_shift_count), 32'hF);
        chk_val("en0_done", 32'(w_done),        32'h1);

        // enable low also blocks load
        do_op(3'b011, 8'h12, 1'b0, 1'b0, 1'b0);
        chk_val("en0_ld_q", 32'(w_q), 32'hFF);

        // ---------------- clear ----------------
        do_op(3'b110, 8'h00, 1'b0, 1'b0, 1'b1);
        chk_val("clr_q",    32'(w_q),           32'h00);
        chk_val("clr_cnt",  32'(w_shift_count), 32'h0);
        chk_val("clr_sout", 32'(w_sout),        32'h0);
        chk_val("clr_done", 32'(w_done),        32'h0);

        // ---------------- reserved mode and hold ----------------
        do_op(3'b011, 8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (4) do_op(3'b111, 8'hFF, 1'b1, 1'b1, 1'b1);
        chk_val("rsv_q",   32'(w_q),           32'h3C);
        chk_val("rsv_cnt", 32'(w_shift_count), 32'h0);
        repeat (2) do_op(3'b000, 8'hFF, 1'b1, 1'b1, 1'b1);
        chk_val("hold_q",   32'(w_q),           32'h3C);
        chk_val("hold_cnt", 32'(w_shift_count), 32'h0);

        // shift right inserts sin_right at the MSB
        do_op(3'b001, 8'h00, 1'b1, 1'b0, 1'b1);
        chk_val("shr_sin_q",    32'(w_q),    32'h9E);
        chk_val("shr_sin_sout", 32'(w_sout), 32'h0);

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
`default_nettype wire
